// File: rtl/ahb_pkg.sv
// ahb_pkg: width-independent AHB-lite types shared by the ahb_master slice
// Contents:
//   htrans_t - transfer type; this initiator only issues IDLE and NONSEQ
package ahb_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        NONSEQ = 2'b10
    } htrans_t;
endpackage

// File: rtl/ahb_cmd_fifo.sv
// ahb_cmd_fifo: synchronous command FIFO in front of the AHB address phase
// Ports:
//   hclk, hresetn  - bus clock, asynchronous active-low reset
//   push, wdata    - write an entry (ignored when full unless popping)
//   pop, rdata     - rdata is the head entry; pop removes it (ignored when empty)
//   full, empty    - occupancy flags
//   count          - number of stored entries
module ahb_cmd_fifo
    import ahb_pkg::*;
#(
    parameter int width = 41,
    parameter int depth = 4
) (
    input  logic                     hclk,
    input  logic                     hresetn,
    input  logic                     push,
    input  logic [width-1:0]         wdata,
    input  logic                     pop,
    output logic [width-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(depth):0]   count
);
    localparam int pw = $clog2(depth);
    localparam int cw = pw + 1;

    logic [width-1:0] mem [depth];
    logic [pw-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full    = count == cw'(depth);
    assign empty   = count == '0;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // Storage needs no reset; only the pointers define validity.
    always_ff @(posedge hclk)
        if (do_push) mem[wr_ptr] <= wdata;

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge hclk or negedge hresetn)
        if (!hresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + cw'(do_push) - cw'(do_pop);
        end
endmodule

// File: rtl/ahb_master.sv
// ahb_master: AHB-lite single-master initiator issuing pipelined NONSEQ single transfers
// Ports:
//   hclk, hresetn                          - bus clock, asynchronous active-low reset
//   cmd_valid/ready, cmd_write/addr/wdata  - command stream into the FIFO
//   rsp_valid, rsp_write, rsp_rdata        - one response pulse per completed transfer
//   idle                                   - nothing queued or in flight
//   hselx, haddr, hwrite, htrans           - address phase outputs
//   hwdata                                 - data phase write data
//   hready, hrdata                         - slave handshake and read data
module ahb_master
    import ahb_pkg::*;
#(
    parameter int addrWidth = 8,
    parameter int dataWidth = 32,
    parameter int fifoDepth = 4
) (
    input  logic                 hclk,
    input  logic                 hresetn,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [addrWidth-1:0] cmd_addr,
    input  logic [dataWidth-1:0] cmd_wdata,
    output logic                 rsp_valid,
    output logic                 rsp_write,
    output logic [dataWidth-1:0] rsp_rdata,
    output logic                 idle,
    output logic                 hselx,
    output logic [addrWidth-1:0] haddr,
    output logic                 hwrite,
    output logic [1:0]           htrans,
    output logic [dataWidth-1:0] hwdata,
    input  logic                 hready,
    input  logic [dataWidth-1:0] hrdata
);
    typedef struct packed {
        logic                 write;
        logic [addrWidth-1:0] addr;
        logic [dataWidth-1:0] wdata;
    } ahb_cmd_t;

    ahb_cmd_t                    cmd_in, head, ap, ap_nxt;
    logic                        ap_valid, dp_valid, dp_write;
    logic [dataWidth-1:0]        dp_wdata;
    logic                        full, empty, pop;
    logic [$clog2(fifoDepth):0]  count;

    assign cmd_in    = {cmd_write, cmd_addr, cmd_wdata};
    assign cmd_ready = !full;
    // The address phase only advances on hready, so the FIFO pops in lockstep.
    assign pop       = hready && !empty;
    assign idle      = count == '0 && !ap_valid && !dp_valid;
    assign htrans    = ap_valid ? NONSEQ : IDLE;
    assign hselx     = ap_valid;
    assign haddr     = ap.addr;
    assign hwrite    = ap.write;
    assign hwdata    = dp_wdata;

    ahb_cmd_fifo #(.width($bits(ahb_cmd_t)), .depth(fifoDepth)) u_fifo (
        .hclk   (hclk),
        .hresetn(hresetn),
        .push   (cmd_valid && cmd_ready),
        .wdata  (cmd_in),
        .pop    (pop),
        .rdata  (head),
        .full   (full),
        .empty  (empty),
        .count  (count)
    );

    // An empty AP is all-zero so haddr/hwrite fall back to 0 and read
    // transfers never put stale data on hwdata.
    always_comb begin
        ap_nxt = empty ? '0 : head;
        if (!head.write) ap_nxt.wdata = '0;
    end

    always_ff @(posedge hclk or negedge hresetn)
        if (!hresetn) begin
            ap        <= '0;
            ap_valid  <= 1'b0;
            dp_valid  <= 1'b0;
            dp_write  <= 1'b0;
            dp_wdata  <= '0;
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= hready && dp_valid;
            if (hready) begin
                if (dp_valid) begin
                    rsp_write <= dp_write;
                    rsp_rdata <= dp_write ? '0 : hrdata;
                end
                dp_valid <= ap_valid;
                dp_write <= ap.write;
                dp_wdata <= ap.wdata;
                ap_valid <= !empty;
                ap       <= ap_nxt;
            end
        end
endmodule

// File: tb/tb_ahb_master.sv
// tb_ahb_master: randomized scoreboard bench for ahb_master with a behavioural memory slave
module tb_ahb_master;
    logic        hclk = 0, hresetn = 0, hready = 1;
    logic        cmd_valid = 0, cmd_write = 0;
    logic [7:0]  cmd_addr = 0;
    logic [31:0] cmd_wdata = 0;
    logic        cmd_ready, rsp_valid, rsp_write, idle, hselx, hwrite;
    logic [31:0] rsp_rdata, hwdata, hrdata;
    logic [7:0]  haddr;
    logic [1:0]  htrans;

    always #5 hclk = ~hclk;

    ahb_master #(.addrWidth(8), .dataWidth(32), .fifoDepth(4)) dut (
        .hclk(hclk), .hresetn(hresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
        .idle(idle), .hselx(hselx), .haddr(haddr), .hwrite(hwrite),
        .htrans(htrans), .hwdata(hwdata), .hready(hready), .hrdata(hrdata)
    );

    // Behavioural AHB memory slave.
    logic [31:0] smem [256];
    logic        sd_valid = 0, sd_write = 0;
    logic [7:0]  sd_addr = 0;
    always @(posedge hclk or negedge hresetn)
        if (!hresetn) sd_valid <= 0;
        else if (hready) begin
            if (sd_valid && sd_write) smem[sd_addr] <= hwdata;
            sd_valid <= hselx && htrans == 2'b10;
            sd_addr  <= haddr;
            sd_write <= hwrite;
        end
    assign hrdata = smem[sd_addr];

    // Reference model: memory updated in command order plus expected-response queue.
    typedef struct packed { logic w; logic [31:0] d; } exp_t;
    logic [31:0] ref_mem [256];
    exp_t        sb[$];
    exp_t        mon_e;

    int compared = 0, mismatched = 0, cyc = 0, rsp_cnt = 0;
    int ns_cyc[$], rsp_cyc[$];
    logic [7:0] ns_addr[$];
    logic rand_hr = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge hclk) cyc <= cyc + 1;

    logic hr_at_edge = 1;
    always @(posedge hclk) hr_at_edge <= hready;

    always @(negedge hclk) if (rand_hr) hready = $urandom_range(0, 2) != 0;

    // Monitor: protocol invariants, stall hold, response scoreboard.
    logic        p_ok = 0, p_hwrite = 0;
    logic [1:0]  p_htrans = 0;
    logic [7:0]  p_haddr = 0;
    logic [31:0] p_hwdata = 0;
    always @(negedge hclk) begin
        if (hresetn) begin
            chk("hselx_eq_nonseq", hselx, htrans == 2'b10);
            chk("htrans_legal", htrans == 2'b00 || htrans == 2'b10, 1);
            if (p_ok && !hr_at_edge) begin
                chk("stall_hold", {htrans, haddr, hwrite, hwdata}, {p_htrans, p_haddr, p_hwrite, p_hwdata});
                chk("stall_no_rsp", rsp_valid, 0);
            end
            if (htrans == 2'b10) begin
                ns_cyc.push_back(cyc);
                ns_addr.push_back(haddr);
            end
            if (rsp_valid) begin
                rsp_cnt++;
                rsp_cyc.push_back(cyc);
                if (sb.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_rsp: got rsp_valid=1 with no command outstanding, required none (cycle %0d)", cyc);
                end else begin
                    mon_e = sb.pop_front();
                    chk("rsp_write", rsp_write, mon_e.w);
                    chk("rsp_rdata", rsp_rdata, mon_e.d);
                end
            end
        end
        p_ok = hresetn;
        p_htrans = htrans;
        p_haddr = haddr;
        p_hwrite = hwrite;
        p_hwdata = hwdata;
    end

    task automatic send(input logic w, input logic [7:0] a, input logic [31:0] d);
        int n = 0;
        cmd_valid = 1;
        cmd_write = w;
        cmd_addr = a;
        cmd_wdata = d;
        while (!cmd_ready && n < 500) begin
            @(negedge hclk);
            n++;
        end
        if (!cmd_ready) chk("cmd_ready_timeout", cmd_ready, 1);
        else begin
            if (w) ref_mem[a] = d;
            sb.push_back('{w: w, d: w ? 32'h0 : ref_mem[a]});
        end
        @(negedge hclk);
        cmd_valid = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(idle && sb.size() == 0) && n < 2000) begin
            @(negedge hclk);
            n++;
        end
        chk("drain_idle", idle, 1);
        chk("drain_sb_empty", sb.size(), 0);
    endtask

    task automatic wait_nonseq(input logic [7:0] a);
        int n = 0;
        while (!(htrans == 2'b10 && haddr == a) && n < 200) begin
            @(negedge hclk);
            n++;
        end
        chk("wait_nonseq", {htrans, haddr}, {2'b10, a});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int r0, ns0, rs0;
        logic [31:0] snap;
        for (int i = 0; i < 256; i++) begin
            smem[i] = (i * 32'h0101_0101) ^ 32'hA5A5_0000;
            ref_mem[i] = smem[i];
        end
        repeat (2) @(negedge hclk);
        chk("reset_bus", {htrans, hselx, haddr, hwrite, hwdata}, 0);
        chk("reset_rsp", {rsp_valid, rsp_write, rsp_rdata}, 0);
        chk("reset_ready_idle", {cmd_ready, idle}, 2'b11);
        hresetn = 1;
        @(negedge hclk);

        // Single write then read back.
        r0 = rsp_cnt;
        send(1, 8'h10, 32'hDEADBEEF);
        chk("t1_not_yet_nonseq", htrans, 2'b00);
        @(negedge hclk);
        chk("t1_nonseq_write", {htrans, haddr, hwrite}, {2'b10, 8'h10, 1'b1});
        @(negedge hclk);
        chk("t1_hwdata", hwdata, 32'hDEADBEEF);
        send(0, 8'h10, 32'h0);
        wait_idle();
        chk("t1_rsp_count", rsp_cnt - r0, 2);

        // Back-to-back write burst.
        ns0 = ns_cyc.size();
        rs0 = rsp_cyc.size();
        for (int i = 0; i < 4; i++) send(1, 8'(i), $urandom);
        wait_idle();
        chk("t2_nonseq_count", ns_cyc.size() - ns0, 4);
        chk("t2_rsp_count", rsp_cyc.size() - rs0, 4);
        for (int i = 0; i < 4; i++) chk("t2_haddr", ns_addr[ns0 + i], 8'(i));
        for (int i = 1; i < 4; i++) begin
            chk("t2_nonseq_consecutive", ns_cyc[ns0 + i] - ns_cyc[ns0 + i - 1], 1);
            chk("t2_rsp_consecutive", rsp_cyc[rs0 + i] - rsp_cyc[rs0 + i - 1], 1);
        end

        // Stall during data phase of a read with a write queued behind it.
        r0 = rsp_cnt;
        send(0, 8'h20, 32'h0);
        send(1, 8'h30, 32'h1234_5678);
        wait_nonseq(8'h30);
        hready = 0;
        snap = hwdata;
        for (int i = 0; i < 3; i++) begin
            @(negedge hclk);
            chk("t3_frozen", {htrans, haddr, hwdata}, {2'b10, 8'h30, snap});
            chk("t3_no_rsp", rsp_cnt - r0, 0);
        end
        hready = 1;
        wait_idle();
        chk("t3_rsp_count", rsp_cnt - r0, 2);

        // FIFO full while the bus is stalled.
        hready = 0;
        r0 = rsp_cnt;
        for (int i = 0; i < 4; i++) send(1, 8'h50 + 8'(i), $urandom);
        chk("t4_full", cmd_ready, 0);
        fork
            send(0, 8'h50, 32'h0);
            begin
                repeat (3) @(negedge hclk);
                chk("t4_still_full", cmd_ready, 0);
                hready = 1;
            end
        join
        wait_idle();
        chk("t4_rsp_count", rsp_cnt - r0, 5);

        // Reset during the data phase of a write.
        send(1, 8'h40, ref_mem[8'h40]);
        wait_nonseq(8'h40);
        @(negedge hclk);
        hresetn = 0;
        #1;
        chk("t5_bus_cleared", {htrans, hselx, haddr, hwrite, hwdata}, 0);
        chk("t5_rsp_cleared", rsp_valid, 0);
        chk("t5_ready_idle", {cmd_ready, idle}, 2'b11);
        sb.delete();
        repeat (2) @(negedge hclk);
        chk("t5_no_rsp_in_reset", rsp_valid, 0);
        hresetn = 1;
        @(negedge hclk);
        r0 = rsp_cnt;
        send(0, 8'h10, 32'h0);
        wait_idle();
        chk("t5_rsp_count", rsp_cnt - r0, 1);

        // Random mixed traffic with random hready.
        rand_hr = 1;
        r0 = rsp_cnt;
        for (int i = 0; i < 50; i++) begin
            send(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), $urandom);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge hclk);
        end
        wait_idle();
        chk("t6_rsp_count", rsp_cnt - r0, 50);
        rand_hr = 0;
        @(negedge hclk);
        hready = 1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
